// File: rtl/harvard_pkg.sv
// Shared encodings for the 16-bit Harvard core control path: sequencer
// states, opcode map, instruction classes, write-back sources and ALU codes.
package harvard_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_EXWAIT = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } seq_state_e;

  // Opcode map, IR[31:26].
  localparam logic [5:0] OP_LDI = 6'h00;
  localparam logic [5:0] OP_MOV = 6'h01;
  localparam logic [5:0] OP_LD  = 6'h02;
  localparam logic [5:0] OP_ST  = 6'h03;
  localparam logic [5:0] OP_ADD = 6'h04;
  localparam logic [5:0] OP_SUB = 6'h05;
  localparam logic [5:0] OP_AND = 6'h06;
  localparam logic [5:0] OP_OR  = 6'h07;
  localparam logic [5:0] OP_XOR = 6'h08;
  localparam logic [5:0] OP_NOT = 6'h09;
  localparam logic [5:0] OP_SHL = 6'h0A;
  localparam logic [5:0] OP_SHR = 6'h0B;
  localparam logic [5:0] OP_ROL = 6'h0C;
  localparam logic [5:0] OP_ROR = 6'h0D;
  localparam logic [5:0] OP_CMP = 6'h0E;
  localparam logic [5:0] OP_BSL = 6'h0F;
  localparam logic [5:0] OP_BSR = 6'h10;

  // Instruction classes produced by the field decoder.
  localparam logic [2:0] CLS_LDI = 3'd0;
  localparam logic [2:0] CLS_MOV = 3'd1;
  localparam logic [2:0] CLS_LD  = 3'd2;
  localparam logic [2:0] CLS_ST  = 3'd3;
  localparam logic [2:0] CLS_ALU = 3'd4;
  localparam logic [2:0] CLS_ILL = 3'd5;

  // Write-back source select.
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;
  localparam logic [1:0] WB_REG = 2'd3;

  // ALU function codes (opcode - OP_ADD).
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOT = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_SHR = 4'd7;
  localparam logic [3:0] ALU_ROL = 4'd8;
  localparam logic [3:0] ALU_ROR = 4'd9;
  localparam logic [3:0] ALU_CMP = 4'd10;
  localparam logic [3:0] ALU_BSL = 4'd11;
  localparam logic [3:0] ALU_BSR = 4'd12;

  // Map an ALU-class opcode onto its ALU function code.
  function automatic logic [3:0] alu_fn(input logic [5:0] opcode);
    logic [5:0] diff;
    diff = opcode - OP_ADD;
    return diff[3:0];
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational field decoder: classifies the opcode in IR and
// extracts the write-back register, write-back source, ALU function and
// data-memory address for the sequencer.
module instr_field_decode
  import harvard_pkg::*;
(
  input  logic [31:0] ir,
  output logic [2:0]  cls,
  output logic [3:0]  alu_op,
  output logic [4:0]  waddr,
  output logic [1:0]  wb_sel,
  output logic [7:0]  dmem_addr
);

  logic [5:0] opcode;
  logic       unused_ir;

  assign opcode    = ir[31:26];
  // IR[15:8] only feeds the immediate, which the top takes straight from IR.
  assign unused_ir = ^ir[15:8];

  // Opcode classification and field extraction.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    cls       = CLS_ILL;
    alu_op    = 4'd0;
    waddr     = 5'd0;
    wb_sel    = WB_ALU;
    dmem_addr = 8'd0;
    case (opcode) inside
      OP_LDI: begin
        cls    = CLS_LDI;
        waddr  = ir[25:21];
        wb_sel = WB_IMM;
      end
      OP_MOV: begin
        cls    = CLS_MOV;
        waddr  = ir[25:21];
        wb_sel = WB_REG;
      end
      OP_LD: begin
        cls       = CLS_LD;
        waddr     = ir[25:21];
        wb_sel    = WB_MEM;
        dmem_addr = ir[7:0];
      end
      OP_ST: begin
        cls       = CLS_ST;
        dmem_addr = ir[25:18];
      end
      [OP_ADD:OP_BSR]: begin
        cls    = CLS_ALU;
        alu_op = alu_fn(opcode);
        waddr  = ir[20:16];
        wb_sel = WB_ALU;
      end
      default: cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer for the 16-bit Harvard core: fetches a
// 32-bit word, decodes it and steps ALU, data memory and register write-back
// one instruction at a time. Illegal opcodes park the sequencer in TRAP.
// Optional build macro SEQ_TIMEOUT_EN bounds the ALU/data-memory waits and
// adds the sticky 'timeout' output.
module instr_seq_ctrl
  import harvard_pkg::*;
#(
  parameter int PC_W     = 16,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic            alu_start,
  output logic [3:0]      alu_op,
  input  logic            alu_done,
  output logic [4:0]      rf_raddr_a,
  output logic [4:0]      rf_raddr_b,
  output logic [4:0]      rf_waddr,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic [15:0]     imm,
  output logic [7:0]      dmem_addr,
  output logic            dmem_re,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            illegal,
  output logic            busy
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic            timeout
`endif
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d;

  logic [2:0]      dec_cls;
  logic [3:0]      dec_alu_op;
  logic [4:0]      dec_waddr;
  logic [1:0]      dec_wb_sel;
  logic [7:0]      dec_dmem_addr;
  logic            fields_en;
  logic            wait_pending;
  logic            wait_expired;

  instr_field_decode u_decode (
    .ir        (ir_q),
    .cls       (dec_cls),
    .alu_op    (dec_alu_op),
    .waddr     (dec_waddr),
    .wb_sel    (dec_wb_sel),
    .dmem_addr (dec_dmem_addr)
  );

  // A handshake wait is still open this cycle (EXWAIT or MEM without ack).
  assign wait_pending = ((state_q == ST_EXWAIT) && !alu_done) ||
                        ((state_q == ST_MEM)    && !dmem_ack);

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = 16;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  assign wait_expired = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
  assign timeout      = timeout_q;

  // Wait counter: counts open-handshake cycles, cleared whenever the wait
  // closes or the state changes; the timeout flag is sticky until reset.
  always_comb begin
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    if (wait_pending) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
      if (wait_expired) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Wait counter and timeout flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
`else
  logic unused_cfg;

  assign wait_expired = 1'b0;
  assign unused_cfg   = (TIMEOUT != 0);
`endif

  // Next-state, PC/IR update and strobe generation.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    alu_start = 1'b0;
    rf_we     = 1'b0;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    fields_en = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // Held low while rst is asserted so every strobe reads 0 in reset.
        imem_req = !rst;
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        fields_en = 1'b1;
        case (dec_cls)
          CLS_LDI, CLS_MOV: state_d = ST_WB;
          CLS_LD, CLS_ST:   state_d = ST_MEM;
          CLS_ALU:          state_d = ST_EXEC;
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_TRAP;
          end
        endcase
      end
      ST_EXEC: begin
        fields_en = 1'b1;
        alu_start = 1'b1;
        state_d   = ST_EXWAIT;
      end
      ST_EXWAIT: begin
        fields_en = 1'b1;
        if (alu_done) begin
          state_d = ST_WB;
        end else if (wait_expired) begin
          state_d = ST_TRAP;
        end
      end
      ST_MEM: begin
        fields_en = 1'b1;
        dmem_re   = (dec_cls == CLS_LD);
        dmem_we   = (dec_cls == CLS_ST);
        if (dmem_ack) begin
          if (dec_cls == CLS_LD) begin
            state_d = ST_WB;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = ST_FETCH;
          end
        end else if (wait_expired) begin
          state_d = ST_TRAP;
        end
      end
      ST_WB: begin
        fields_en = 1'b1;
        rf_we     = 1'b1;
        pc_d      = pc_q + PC_W'(1);
        state_d   = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // Sequencer state, PC, instruction register and sticky illegal flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= PC_W'(RESET_PC);
      ir_q      <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Decoded fields are presented from DECODE until the instruction retires
  // and read as 0 in FETCH and TRAP.
  assign rf_waddr   = fields_en ? dec_waddr     : 5'd0;
  assign wb_sel     = fields_en ? dec_wb_sel    : WB_ALU;
  assign alu_op     = fields_en ? dec_alu_op    : 4'd0;
  assign dmem_addr  = fields_en ? dec_dmem_addr : 8'd0;
  assign rf_raddr_a = ir_q[9:5];
  assign rf_raddr_b = ir_q[4:0];
  assign imm        = ir_q[15:0];
  assign imem_addr  = pc_q;
  assign illegal    = illegal_q;
  assign busy       = (state_q != ST_TRAP);

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Scoreboard bench for instr_seq_ctrl: the stimulus process queues expected
// write-back, ALU-launch and data-memory transactions; a monitor pops and
// compares them whenever the DUT presents the matching strobe.
module tb_instr_seq_ctrl;
  import harvard_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ack, alu_done, dmem_ack;
  logic [31:0] imem_data;

  logic [15:0] imem_addr, imm;
  logic        imem_req, alu_start, rf_we, dmem_re, dmem_we, illegal, busy;
  logic [3:0]  alu_op;
  logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [1:0]  wb_sel;
  logic [7:0]  dmem_addr;

  logic [1:0]  w_imem_addr;
  logic [15:0] w_imm;
  logic        w_imem_req, w_alu_start, w_rf_we, w_dmem_re, w_dmem_we, w_illegal, w_busy;
  logic [3:0]  w_alu_op;
  logic [4:0]  w_rf_raddr_a, w_rf_raddr_b, w_rf_waddr;
  logic [1:0]  w_wb_sel;
  logic [7:0]  w_dmem_addr;
`ifdef SEQ_TIMEOUT_EN
  logic        timeout, w_timeout;
`endif

  always #5 clk = ~clk;

  instr_seq_ctrl #(.PC_W(16), .RESET_PC(0), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_start(alu_start), .alu_op(alu_op), .alu_done(alu_done),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr), .rf_we(rf_we),
    .wb_sel(wb_sel), .imm(imm),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .illegal(illegal), .busy(busy)
`ifdef SEQ_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  // Narrow-PC copy running in lockstep; starts at the top PC to show the wrap.
  instr_seq_ctrl #(.PC_W(2), .RESET_PC(3), .TIMEOUT(15)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_addr(w_imem_addr), .imem_req(w_imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_start(w_alu_start), .alu_op(w_alu_op), .alu_done(alu_done),
    .rf_raddr_a(w_rf_raddr_a), .rf_raddr_b(w_rf_raddr_b), .rf_waddr(w_rf_waddr), .rf_we(w_rf_we),
    .wb_sel(w_wb_sel), .imm(w_imm),
    .dmem_addr(w_dmem_addr), .dmem_re(w_dmem_re), .dmem_we(w_dmem_we), .dmem_ack(dmem_ack),
    .illegal(w_illegal), .busy(w_busy)
`ifdef SEQ_TIMEOUT_EN
    , .timeout(w_timeout)
`endif
  );

  typedef struct {
    logic [4:0]  waddr;
    logic [1:0]  wb_sel;
    logic [15:0] imm;
    logic [4:0]  ra;
    logic [4:0]  rb;
  } wb_exp_t;

  typedef struct {
    logic [7:0] addr;
    logic       is_st;
    logic [4:0] rb;
  } mem_exp_t;

  wb_exp_t    wb_q[$];
  mem_exp_t   mem_q[$];
  logic [3:0] alu_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bounded wait at negedges: 0 = imem_req, 1 = alu_start, 2 = dmem_re/we.
  task automatic wait_for(input int which, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((which == 0 && imem_req) || (which == 1 && alu_start) ||
          (which == 2 && (dmem_we || dmem_re))) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!hit) check({name, "_wait_expired"}, 32'd0, 32'd1);
  endtask

  // Present one instruction word with ack in the first requesting cycle.
  task automatic fetch(input logic [31:0] word, input logic [15:0] exp_pc, input string name);
    wait_for(0, name);
    check({name, "_imem_addr"}, 32'(imem_addr), 32'(exp_pc));
    imem_data = word;
    imem_ack  = 1'b1;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 32'hFFFF_FFFF;
  endtask

  // LDI/MOV: expect rf_we on the third cycle counted from the fetch cycle.
  task automatic run_wb(input logic [31:0] word, input logic [15:0] pc, input string name);
    int k;
    fetch(word, pc, name);
    k = 1;
    while (!rf_we && k < 8) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, 32'(k + 1), 32'd3);
    @(negedge clk);
    check({name, "_next_pc"}, 32'(imem_addr), 32'(pc) + 32'd1);
  endtask

  // Monitor: pops and compares whenever the DUT presents a transaction.
  initial begin
    wb_exp_t  we;
    mem_exp_t me;
    logic [3:0] ae;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (rf_we) begin
          if (wb_q.size() == 0) begin
            check("unexpected_rf_we", 32'd1, 32'd0);
          end else begin
            we = wb_q.pop_front();
            check("wb_waddr",  32'(rf_waddr),   32'(we.waddr));
            check("wb_sel",    32'(wb_sel),     32'(we.wb_sel));
            check("wb_imm",    32'(imm),        32'(we.imm));
            check("wb_raddr_a", 32'(rf_raddr_a), 32'(we.ra));
            check("wb_raddr_b", 32'(rf_raddr_b), 32'(we.rb));
          end
        end
        if (alu_start) begin
          if (alu_q.size() == 0) begin
            check("unexpected_alu_start", 32'd1, 32'd0);
          end else begin
            ae = alu_q.pop_front();
            check("alu_op", 32'(alu_op), 32'(ae));
          end
        end
        if ((dmem_re || dmem_we) && dmem_ack) begin
          if (mem_q.size() == 0) begin
            check("unexpected_dmem", 32'd1, 32'd0);
          end else begin
            me = mem_q.pop_front();
            check("mem_addr", 32'(dmem_addr), 32'(me.addr));
            check("mem_we",   32'(dmem_we),   32'(me.is_st));
            check("mem_re",   32'(dmem_re),   32'(!me.is_st));
            check("mem_raddr_b", 32'(rf_raddr_b), 32'(me.rb));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  any;
    rst       = 1'b1;
    imem_ack  = 1'b0;
    imem_data = 32'd0;
    alu_done  = 1'b0;
    dmem_ack  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_req",  32'(imem_req),  32'd0);
    check("rst_strobes",   32'({rf_we, alu_start, dmem_re, dmem_we}), 32'd0);
    check("rst_illegal",   32'(illegal),   32'd0);
    check("rst_fields",    32'({rf_waddr, wb_sel, dmem_addr}), 32'd0);
    check("rst_imm",       32'(imm),       32'd0);
    check("rst_wrap_pc",   32'(w_imem_addr), 32'd3);
`ifdef SEQ_TIMEOUT_EN
    check("rst_timeout",   32'(timeout),   32'd0);
`endif
    rst = 1'b0;

    // LDI r5, 0x1234: raddr_a = 17, raddr_b = 20 fall out of the immediate.
    wb_q.push_back(wb_exp_t'{5'd5, WB_IMM, 16'h1234, 5'd17, 5'd20});
    run_wb(32'h00A0_1234, 16'd0, "ldi");
    check("wrap_pc_to_zero", 32'(w_imem_addr), 32'd0);

    // MOV r6 <- r7.
    wb_q.push_back(wb_exp_t'{5'd6, WB_REG, 16'h0007, 5'd0, 5'd7});
    run_wb(32'h04C0_0007, 16'd1, "mov");

    // ADD r1 <- r2, r1 with alu_done three cycles after alu_start.
    alu_q.push_back(ALU_ADD);
    wb_q.push_back(wb_exp_t'{5'd1, WB_ALU, 16'h0041, 5'd2, 5'd1});
    fetch(32'h1001_0041, 16'd2, "add");
    wait_for(1, "add_start");
    @(negedge clk);
    check("add_start_single", 32'(alu_start), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("add_no_we_before_done", 32'(rf_we), 32'd0);
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    check("add_we_after_done", 32'(rf_we), 32'd1);
    @(negedge clk);
    check("add_next_pc", 32'(imem_addr), 32'd3);

    // ST to 0x0A from r3 with dmem_ack delayed two cycles.
    mem_q.push_back(mem_exp_t'{8'h0A, 1'b1, 5'd3});
    fetch(32'h0C28_0003, 16'd3, "st");
    wait_for(2, "st_mem");
    n = 0;
    for (int k = 0; k < 3; k++) begin
      if (dmem_we) n++;
      if (k == 2) dmem_ack = 1'b1;
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    check("st_we_cycles",  32'(n),         32'd3);
    check("st_we_dropped", 32'(dmem_we),   32'd0);
    check("st_next_pc",    32'(imem_addr), 32'd4);
    check("st_refetch",    32'(imem_req),  32'd1);

    // LD r5 <- mem[0xFF], zero-wait ack.
    mem_q.push_back(mem_exp_t'{8'hFF, 1'b0, 5'd31});
    wb_q.push_back(wb_exp_t'{5'd5, WB_MEM, 16'h00FF, 5'd7, 5'd31});
    fetch(32'h08A0_00FF, 16'd4, "ld");
    wait_for(2, "ld_mem");
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("ld_we_after_ack", 32'(rf_we), 32'd1);
    @(negedge clk);
    check("ld_next_pc", 32'(imem_addr), 32'd5);

    // Reset during EXWAIT aborts: no write-back, PC back to RESET_PC.
    alu_q.push_back(ALU_ADD);
    fetch(32'h1001_0041, 16'd5, "abort");
    wait_for(1, "abort_start");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_pc", 32'(imem_addr), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    check("abort_in_fetch", 32'(imem_req), 32'd1);
    check("abort_pc_held",  32'(imem_addr), 32'd0);

    // Illegal opcode 0x11 traps; nothing moves until reset.
    fetch(32'h4400_0000, 16'd0, "ill");
    check("ill_flag_in_decode", 32'(illegal), 32'd0);
    @(negedge clk);
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_busy", 32'(busy),    32'd0);
    imem_ack = 1'b1;
    alu_done = 1'b1;
    dmem_ack = 1'b1;
    any      = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (imem_req || rf_we || alu_start || dmem_re || dmem_we) any = 1'b1;
    end
    imem_ack = 1'b0;
    alu_done = 1'b0;
    dmem_ack = 1'b0;
    check("trap_quiet",  32'(any),     32'd0);
    check("trap_sticky", 32'(illegal), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("trap_rst_illegal", 32'(illegal), 32'd0);
    check("trap_rst_busy",    32'(busy),    32'd1);

`ifdef SEQ_TIMEOUT_EN
    // alu_done never arrives: timeout after 15 EXWAIT cycles, then TRAP.
    alu_q.push_back(ALU_ADD);
    fetch(32'h1001_0041, 16'd0, "to");
    wait_for(1, "to_start");
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (timeout) begin
        n = k;
        break;
      end
    end
    check("to_cycles", 32'(n),         32'd16);
    check("to_busy",   32'(busy),      32'd0);
    check("to_pc",     32'(imem_addr), 32'd0);
`endif

    @(negedge clk);
    check("wb_queue_drained",  32'(wb_q.size()),  32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    check("alu_queue_drained", 32'(alu_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
